// File: rtl/instr_loop_buffer.sv
// Captures one host instruction sequence into RAM, then replays it: a prologue once, then a loop region N times or until STOP.
// Latency: first replayed word is valid 2 cycles after the END word is accepted; then 1 word/cycle sustained.
// Backpressure: out_ready low freezes out_instr and the read pointer; in_ready is high only in FILL and LOOP.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_loop_cnt          loop iterations (0 = run until a STOP word), sampled when leaving IDLE
//   in_valid/in_ready     host word handshake, in_instr = host word
//   out_valid/out_ready   replay handshake, out_instr = replayed word
//   busy, looping, done   status: not idle / replaying / one-cycle completion pulse
//   overflow              sticky: a capture word was dropped because the RAM was full
//   state_out             current state encoding
// Optional build macro INSTR_BUF_STATS_EN adds iter_cnt (completed loop iterations)
// and stall_cnt (saturating count of cycles with out_valid & ~out_ready).
module instr_loop_buffer #(
  parameter int         INSTR_W    = 32,
  parameter int         ADDR_W     = 11,
  parameter int         LOOP_START = 512,
  parameter int         LCNT_W     = 16,
  parameter logic [3:0] OPC_STOP   = 4'b1110,
  parameter logic [3:0] OPC_END    = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LCNT_W-1:0]  cfg_loop_cnt,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic               busy,
  output logic               looping,
  output logic               overflow,
  output logic               done,
  output logic [2:0]         state_out
`ifdef INSTR_BUF_STATS_EN
  ,
  output logic [LCNT_W-1:0]  iter_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LS_P    = (ADDR_W+1)'(LOOP_START);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_PROLOGUE = 3'd2;
  localparam logic [2:0] S_LOOP     = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;    // next address to read from RAM
  logic [ADDR_W:0]    pf_addr_q, pf_addr_d;  // address of the word held in the prefetch register
  logic               pf_vld_q, pf_vld_d;
  logic [LCNT_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [LCNT_W-1:0]  iter_q, iter_d;
  logic               overflow_q, overflow_d;
  logic [INSTR_W-1:0] pf_dat_q;
  logic [INSTR_W-1:0] mem [DEPTH];

  logic              replay, hs, rd_fire, in_fire, full, wr_en;
  logic              at_plast, at_last, stop_in, cnt_hit;
  logic [ADDR_W:0]   plen;
  logic [3:0]        in_opc;
  logic [LCNT_W-1:0] iter_inc;

  assign replay   = (state_q == S_PROLOGUE) || (state_q == S_LOOP) || (state_q == S_DRAIN);
  assign out_valid = pf_vld_q & replay;
  assign out_instr = pf_dat_q;
  assign hs       = out_valid & out_ready;
  // The RAM output register doubles as the prefetch stage: it reloads whenever
  // it is empty or its word is being taken, so a stall simply freezes it.
  assign rd_fire  = replay & (~pf_vld_q | out_ready);

  assign in_ready = (state_q == S_FILL) || (state_q == S_LOOP);
  assign in_fire  = in_valid & in_ready;
  assign in_opc   = in_instr[INSTR_W-1 -: 4];
  assign full     = wr_ptr_q[ADDR_W];  // wr_ptr never exceeds DEPTH
  assign wr_en    = (state_q == S_FILL) & in_fire & ~full;
  assign stop_in  = (state_q == S_LOOP) & in_fire & (in_opc == OPC_STOP);

  assign plen     = (len_q > LS_P) ? LS_P : len_q;
  assign at_plast = (pf_addr_q == plen - 1'b1);
  assign at_last  = (pf_addr_q == len_q - 1'b1);
  assign iter_inc = iter_q + 1'b1;
  assign cnt_hit  = (loop_cnt_q != '0) && (iter_inc == loop_cnt_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    pf_addr_d  = pf_addr_q;
    pf_vld_d   = pf_vld_q;
    loop_cnt_d = loop_cnt_q;
    iter_d     = iter_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_FILL;
          loop_cnt_d = cfg_loop_cnt;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
          iter_d     = '0;
        end
      end
      S_FILL: begin
        if (in_fire) begin
          if (full) overflow_d = 1'b1;
          else      wr_ptr_d   = wr_ptr_q + 1'b1;
          if (in_opc == OPC_END) begin
            len_d    = full ? DEPTH_P : wr_ptr_q + 1'b1;
            rd_ptr_d = '0;
            state_d  = S_PROLOGUE;
          end
        end
      end
      S_PROLOGUE: begin
        if (hs && at_plast) state_d = (len_q > LS_P) ? S_LOOP : S_DONE;
      end
      S_LOOP, S_DRAIN: begin
        if (hs && at_last) begin
          iter_d = iter_inc;
          // A STOP landing on the final word of an iteration ends right here.
          if (state_q == S_DRAIN || stop_in || cnt_hit) state_d = S_DONE;
        end else if (stop_in) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rd_fire) begin
      pf_addr_d = rd_ptr_q;
      pf_vld_d  = 1'b1;
      rd_ptr_d  = (rd_ptr_q == len_q - 1'b1) ? LS_P : rd_ptr_q + 1'b1;
    end
    // A read issued alongside the final handshake is discarded on exit.
    if (!((state_d == S_PROLOGUE) || (state_d == S_LOOP) || (state_d == S_DRAIN)))
      pf_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      pf_addr_q  <= '0;
      pf_vld_q   <= 1'b0;
      loop_cnt_q <= '0;
      iter_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      pf_addr_q  <= pf_addr_d;
      pf_vld_q   <= pf_vld_d;
      loop_cnt_q <= loop_cnt_d;
      iter_q     <= iter_d;
      overflow_q <= overflow_d;
    end
  end

  // Inferred simple dual-port RAM with registered read; no reset on contents.
  always_ff @(posedge clk) begin
    if (wr_en)   mem[wr_ptr_q[ADDR_W-1:0]] <= in_instr;
    if (rd_fire) pf_dat_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign busy      = (state_q != S_IDLE);
  assign looping   = replay;
  assign overflow  = overflow_q;
  assign done      = (state_q == S_DONE);
  assign state_out = state_q;

`ifdef INSTR_BUF_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign iter_cnt  = iter_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_loop_buffer.sv
module tb_instr_loop_buffer;

  localparam logic [3:0] OPC_NORM = 4'h1;
  localparam logic [3:0] OPC_STOP = 4'hE;
  localparam logic [3:0] OPC_END  = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic [31:0] in_instr  [2];
  logic [15:0] cfg       [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_instr [2];
  logic        busy      [2];
  logic        looping   [2];
  logic        overflow  [2];
  logic        done      [2];
  logic [2:0]  state_out [2];
`ifdef INSTR_BUF_STATS_EN
  logic [15:0] iter_cnt  [2];
  logic [31:0] stall_cnt [2];
`endif

  always #5 clk = ~clk;

  // Instance 0: default geometry (LOOP_START=512). Instance 1: 8-word RAM, LOOP_START=2.
  instr_loop_buffer u_dut_a (
    .clk(clk), .rst(rst), .cfg_loop_cnt(cfg[0]),
    .in_valid(in_valid[0]), .in_instr(in_instr[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_instr(out_instr[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .looping(looping[0]), .overflow(overflow[0]), .done(done[0]),
    .state_out(state_out[0])
`ifdef INSTR_BUF_STATS_EN
    , .iter_cnt(iter_cnt[0]), .stall_cnt(stall_cnt[0])
`endif
  );

  instr_loop_buffer #(.ADDR_W(3), .LOOP_START(2)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_loop_cnt(cfg[1]),
    .in_valid(in_valid[1]), .in_instr(in_instr[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_instr(out_instr[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .looping(looping[1]), .overflow(overflow[1]), .done(done[1]),
    .state_out(state_out[1])
`ifdef INSTR_BUF_STATS_EN
    , .iter_cnt(iter_cnt[1]), .stall_cnt(stall_cnt[1])
`endif
  );

  int          nchecks = 0;
  int          nerrs   = 0;
  int          nwords    [2];
  logic        saw_loop  [2];
  logic        held_vld  [2];
  logic [31:0] held_dat  [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] w [10];
  logic        toggle_en = 1'b0;
  logic [31:0] mon_e;
  logic        mon_have;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] opc, input int i);
    return {opc, 12'hA5C, 16'(i)};
  endfunction

  // Builds w[0..n-1] with distinct payloads; the last word carries END.
  task automatic build(input int base, input int n);
    for (int i = 0; i < n; i++) w[i] = mk(OPC_NORM, base + i);
    w[n-1] = mk(OPC_END, base + n - 1);
  endtask

  task automatic push(input int d, input int idx);
    if (d == 0) exp_q0.push_back(w[idx]);
    else        exp_q1.push_back(w[idx]);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Starts and ends at posedge+1.
  task automatic send(input int d, input logic [31:0] word);
    bit ok = 0;
    in_valid[d] = 1'b1;
    in_instr[d] = word;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready[d]) begin ok = 1; break; end
    end
    chk("send accepted", 32'(ok), 1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic fill(input int d, input int n, input logic [15:0] cnt);
    cfg[d] = cnt;
    for (int i = 0; i < n; i++) send(d, w[i]);
  endtask

  // Counts negedges from the cycle after END acceptance until done is seen.
  task automatic wait_done(input int d, input int exp_cyc, input string name);
    bit got = 0;
    int cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      cyc = k;
      if (done[d]) begin got = 1; break; end
    end
    chk({name, " done seen"}, 32'(got), 1);
    if (exp_cyc >= 0) chk({name, " done latency"}, 32'(cyc), 32'(exp_cyc));
    @(posedge clk); #1;
    chk({name, " idle after done"}, 32'(state_out[d]), 0);
    chk({name, " done one cycle"}, 32'(done[d]), 0);
    chk({name, " all words seen"}, 32'(qsize(d)), 0);
  endtask

  task automatic wait_words(input int d, input int n, input string name);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (nwords[d] >= n) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({name, " words reached"}, 32'(ok), 1);
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on every handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        held_vld[d] = 1'b0;
      end else begin
        if (held_vld[d]) begin
          chk("stall valid held", 32'(out_valid[d]), 1);
          chk("stall data held", out_instr[d], held_dat[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          nwords[d]++;
          mon_have = (qsize(d) != 0);
          if (mon_have) begin
            mon_e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("replay word", out_instr[d], mon_e);
          end else begin
            nchecks++;
            nerrs++;
            $display("FAIL unexpected word: dut %0d got %h expected none", d, out_instr[d]);
          end
        end
        held_vld[d] = out_valid[d] && !out_ready[d];
        held_dat[d] = out_instr[d];
        if (state_out[d] == 3'd3) saw_loop[d] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (toggle_en) out_ready[1] = !out_ready[1];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_instr[d] = '0; cfg[d] = '0; out_ready[d] = 1'b1;
      nwords[d] = 0; saw_loop[d] = 1'b0; held_vld[d] = 1'b0; held_dat[d] = '0;
    end
    #12;
    chk("reset state", 32'(state_out[1]), 0);
    chk("reset out_valid", 32'(out_valid[1]), 0);
    chk("reset in_ready", 32'(in_ready[1]), 0);
    chk("reset done", 32'(done[1]), 0);
    chk("reset overflow", 32'(overflow[1]), 0);
    chk("reset busy", 32'(busy[0]), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: short sequence, LOOP_START beyond len -> prologue only.
    build(0, 4);
    for (int i = 0; i < 4; i++) push(0, i);
    fill(0, 4, 16'd0);
    wait_done(0, 6, "t1");
    chk("t1 words", 32'(nwords[0]), 4);
    chk("t1 never in LOOP", 32'(saw_loop[0]), 0);

    // 2: prologue w0 w1, loop (w2 w3 w4) x3, back-to-back.
    build(100, 5);
    push(1, 0); push(1, 1);
    for (int r = 0; r < 3; r++) for (int j = 2; j < 5; j++) push(1, j);
    nwords[1] = 0; saw_loop[1] = 1'b0;
    fill(1, 5, 16'd3);
    wait_done(1, 13, "t2");
    chk("t2 words", 32'(nwords[1]), 11);
    chk("t2 entered LOOP", 32'(saw_loop[1]), 1);

    // 3: infinite loop, STOP after 7 loop words -> finish current iteration.
    build(200, 5);
    push(1, 0); push(1, 1);
    for (int r = 0; r < 3; r++) for (int j = 2; j < 5; j++) push(1, j);
    nwords[1] = 0;
    fill(1, 5, 16'd0);
    wait_words(1, 9, "t3");
    send(1, mk(OPC_STOP, 0));
    wait_done(1, -1, "t3");
    chk("t3 words", 32'(nwords[1]), 11);

    // 4: as case 2 with out_ready toggling every cycle.
    build(300, 5);
    push(1, 0); push(1, 1);
    for (int r = 0; r < 3; r++) for (int j = 2; j < 5; j++) push(1, j);
    nwords[1] = 0;
    toggle_en = 1'b1;
    fill(1, 5, 16'd3);
    wait_done(1, -1, "t4");
    toggle_en = 1'b0;
    out_ready[1] = 1'b1;
    chk("t4 words", 32'(nwords[1]), 11);

    // 5: 10 words into an 8-word RAM -> words 8,9 dropped, len=8.
    build(400, 10);
    for (int i = 0; i < 8; i++) push(1, i);
    nwords[1] = 0;
    fill(1, 10, 16'd1);
    chk("t5 overflow set", 32'(overflow[1]), 1);
    wait_done(1, -1, "t5");
    chk("t5 words", 32'(nwords[1]), 8);
    chk("t5 overflow sticky", 32'(overflow[1]), 1);

    // 6: reset in the middle of an infinite loop, then a normal run.
    build(500, 5);
    push(1, 0); push(1, 1); push(1, 2); push(1, 3); push(1, 4); push(1, 2);
    nwords[1] = 0;
    fill(1, 5, 16'd0);
    chk("t6 overflow cleared", 32'(overflow[1]), 0);
    wait_words(1, 6, "t6");
    chk("t6 in LOOP", 32'(state_out[1]), 3);
    chk("t6 looping", 32'(looping[1]), 1);
    chk("t6 busy", 32'(busy[1]), 1);
    chk("t6 valid before reset", 32'(out_valid[1]), 1);
    rst = 1'b1;
    #1;
    chk("t6 async out_valid", 32'(out_valid[1]), 0);
    chk("t6 async state", 32'(state_out[1]), 0);
    chk("t6 queue drained", 32'(qsize(1)), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    build(600, 5);
    for (int i = 0; i < 5; i++) push(1, i);
    nwords[1] = 0;
    fill(1, 5, 16'd1);
    wait_done(1, 7, "t6 refill");
    chk("t6 refill words", 32'(nwords[1]), 5);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
